// File: rtl/spi_prog_slave_if.sv
// SPI pad and memory write-port bundle for spi_prog_slave.
// The slave modport is the programming block; the master modport is the pads plus the memory side.
interface spi_prog_slave_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              sclk_i;
  logic              cs_ni;
  logic              mosi_i;
  logic              miso_o;
  logic              mem_we_o;
  logic [ADDR_W-1:0] mem_addr_o;
  logic [DATA_W-1:0] mem_wdata_o;
  logic              mem_ready_i;
  logic              err_o;

  modport slave (
    input  sclk_i, cs_ni, mosi_i, mem_ready_i,
    output miso_o, mem_we_o, mem_addr_o, mem_wdata_o, err_o
  );

  modport master (
    output sclk_i, cs_ni, mosi_i, mem_ready_i,
    input  miso_o, mem_we_o, mem_addr_o, mem_wdata_o, err_o
  );
endinterface

// File: rtl/spi_prog_slave.sv
// SPI mode-0 programming slave: 0x01 + address bytes, 0x02 + data bytes -> one memory write.
// Optional SPI_PROG_ADDR_AUTOINC_EN: bump the address by one word after every accepted write.
module spi_prog_slave #(
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int SYNC_STG = 2
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  spi_prog_slave_if.slave  bus
);

  localparam int ADDR_BYTES = (ADDR_W + 7) / 8;
  localparam int DATA_BYTES = DATA_W / 8;
  localparam int CNT_W      = 8;

  typedef enum logic [1:0] {S_CMD, S_ADDR, S_DATA, S_WRITE} state_t;

  state_t              state, state_d;
  logic [SYNC_STG-1:0] sclk_sync, cs_sync, mosi_sync;
  logic                sclk_s, cs_s, mosi_s, sclk_q, cs_q;
  logic                sclk_rise, sclk_fall, cs_fall;
  logic [2:0]          bit_cnt;
  logic [7:0]          rx_sh, rx_next, echo;
  logic [6:0]          tx_sh;
  logic                byte_vld, miso_q;
  logic [CNT_W-1:0]    cnt;
  logic [ADDR_W-1:0]   addr_sh, addr_next, mem_addr;
  logic [DATA_W-1:0]   data_sh, data_next, mem_wdata;
  logic                mem_we, err;
  logic                err_set, addr_done, data_done, accept;

  // CS synchronizer resets to idle-high so reset release never looks like a CS fall.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sclk_sync <= '0;
      cs_sync   <= '1;
      mosi_sync <= '0;
      sclk_q    <= 1'b0;
      cs_q      <= 1'b1;
    end else begin
      sclk_sync <= {sclk_sync[SYNC_STG-2:0], bus.sclk_i};
      cs_sync   <= {cs_sync[SYNC_STG-2:0], bus.cs_ni};
      mosi_sync <= {mosi_sync[SYNC_STG-2:0], bus.mosi_i};
      sclk_q    <= sclk_s;
      cs_q      <= cs_s;
    end
  end

  assign sclk_s    = sclk_sync[SYNC_STG-1];
  assign cs_s      = cs_sync[SYNC_STG-1];
  assign mosi_s    = mosi_sync[SYNC_STG-1];
  assign sclk_rise = sclk_s & ~sclk_q;
  assign sclk_fall = ~sclk_s & sclk_q;
  assign cs_fall   = cs_q & ~cs_s;
  assign rx_next   = {rx_sh[6:0], mosi_s};

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      bit_cnt  <= '0;
      rx_sh    <= '0;
      echo     <= '0;
      byte_vld <= 1'b0;
    end else begin
      byte_vld <= 1'b0;
      if (cs_s) begin
        bit_cnt <= '0;
      end else if (sclk_rise) begin
        rx_sh <= rx_next;
        if (bit_cnt == 3'd7) begin
          bit_cnt  <= '0;
          byte_vld <= 1'b1;
          echo     <= rx_next;
        end else begin
          bit_cnt <= bit_cnt + 3'd1;
        end
      end
    end
  end

  // A fall with bit_cnt==0 starts a new byte when CS stays low, so the echo is reloaded there too.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      miso_q <= 1'b0;
      tx_sh  <= '0;
    end else if (cs_s) begin
      miso_q <= 1'b0;
      tx_sh  <= '0;
    end else if (cs_fall || (sclk_fall && bit_cnt == 3'd0)) begin
      miso_q <= echo[7];
      tx_sh  <= echo[6:0];
    end else if (sclk_fall) begin
      miso_q <= tx_sh[6];
      tx_sh  <= {tx_sh[5:0], 1'b0};
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state <= S_CMD;
    else         state <= state_d;
  end

  always_comb begin
    state_d   = state;
    err_set   = 1'b0;
    addr_done = 1'b0;
    data_done = 1'b0;
    accept    = 1'b0;
    case (state)
      S_CMD: begin
        if (byte_vld) begin
          if (echo == 8'h01)      state_d = S_ADDR;
          else if (echo == 8'h02) state_d = S_DATA;
          else                    err_set = 1'b1;
        end
      end
      S_ADDR: begin
        if (byte_vld && cnt == CNT_W'(ADDR_BYTES - 1)) begin
          addr_done = 1'b1;
          state_d   = S_CMD;
        end
      end
      S_DATA: begin
        if (byte_vld && cnt == CNT_W'(DATA_BYTES - 1)) begin
          data_done = 1'b1;
          state_d   = S_WRITE;
        end
      end
      S_WRITE: begin
        if (bus.mem_ready_i) begin
          accept  = 1'b1;
          state_d = S_CMD;
        end
        if (byte_vld) err_set = 1'b1;
      end
      default: state_d = S_CMD;
    endcase
  end

  assign addr_next = ADDR_W'({addr_sh, echo});
  assign data_next = DATA_W'({data_sh, echo});

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt       <= '0;
      addr_sh   <= '0;
      data_sh   <= '0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_we    <= 1'b0;
      err       <= 1'b0;
    end else begin
      if (state == S_CMD && byte_vld)
        cnt <= '0;
      else if ((state == S_ADDR || state == S_DATA) && byte_vld)
        cnt <= cnt + CNT_W'(1);
      if (state == S_ADDR && byte_vld) addr_sh <= addr_next;
      if (state == S_DATA && byte_vld) data_sh <= data_next;
`ifdef SPI_PROG_ADDR_AUTOINC_EN
      if (addr_done)   mem_addr <= addr_next;
      else if (accept) mem_addr <= mem_addr + ADDR_W'(DATA_W / 8);
`else
      if (addr_done)   mem_addr <= addr_next;
`endif
      if (data_done) begin
        mem_wdata <= data_next;
        mem_we    <= 1'b1;
      end else if (accept) begin
        mem_we <= 1'b0;
      end
      if (err_set) err <= 1'b1;
    end
  end

  assign bus.miso_o      = miso_q;
  assign bus.mem_we_o    = mem_we;
  assign bus.mem_addr_o  = mem_addr;
  assign bus.mem_wdata_o = mem_wdata;
  assign bus.err_o       = err;

endmodule

// File: tb/tb_spi_prog_slave.sv
// Directed bench for spi_prog_slave: expected writes go into a queue, a monitor pops them on each accepted write.
// Honours SPI_PROG_ADDR_AUTOINC_EN for the back-to-back data frame case.
module tb_spi_prog_slave;

  localparam int HALF = 8;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
  } wr_t;

  logic       clk = 1'b0;
  logic       rst_n;
  int         vectors = 0;
  int         miscompares = 0;
  int         write_cnt = 0;
  wr_t        exp_q[$];
  logic [7:0] miso_cap;

  spi_prog_slave_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  spi_prog_slave #(.ADDR_W(32), .DATA_W(32), .SYNC_STG(2)) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic check_output(input string name, input logic [71:0] act, input logic [71:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic wait_clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  // One CS-framed byte, MSB first; MISO is sampled just before each rising SCLK.
  task automatic apply_stimulus(input logic [7:0] b, input int nbits = 8);
    bus.cs_ni = 1'b0;
    wait_clks(HALF);
    for (int i = 0; i < nbits; i++) begin
      bus.mosi_i = b[7-i];
      wait_clks(HALF);
      miso_cap[7-i] = bus.miso_o;
      bus.sclk_i = 1'b1;
      wait_clks(HALF);
      bus.sclk_i = 1'b0;
    end
    wait_clks(HALF);
    bus.cs_ni = 1'b1;
    wait_clks(HALF);
  endtask

  task automatic send_frame(input logic [7:0] cmd, input logic [31:0] val);
    apply_stimulus(cmd);
    for (int i = 3; i >= 0; i--) apply_stimulus(val[i*8 +: 8]);
  endtask

  task automatic wait_drain(input string name, input int budget);
    int n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("[TB] FAIL %s: %0d writes still pending, expected 0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  function automatic wr_t mk(input logic [31:0] a, input logic [31:0] d);
    wr_t w;
    w.addr = a;
    w.data = d;
    return w;
  endfunction

  // Monitor: every accepted write must match the oldest expected write.
  initial begin
    wr_t e;
    forever begin
      @(negedge clk);
      #1;
      if (rst_n && bus.mem_we_o && bus.mem_ready_i) begin
        write_cnt++;
        if (exp_q.size() == 0) begin
          vectors++;
          miscompares++;
          $display("[TB] FAIL unexpected_write: got addr 0x%08h data 0x%08h, expected none",
                   bus.mem_addr_o, bus.mem_wdata_o);
        end else begin
          e = exp_q.pop_front();
          check_output("wr_addr", 72'(bus.mem_addr_o), 72'(e.addr));
          check_output("wr_data", 72'(bus.mem_wdata_o), 72'(e.data));
        end
      end
    end
  end

  initial begin
    #1ms;
    $display("[TB] FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [31:0] second_addr;
    rst_n           = 1'b0;
    bus.sclk_i      = 1'b0;
    bus.cs_ni       = 1'b1;
    bus.mosi_i      = 1'b0;
    bus.mem_ready_i = 1'b1;
    wait_clks(3);
    check_output("rst_miso",  72'(bus.miso_o), 72'(0));
    check_output("rst_we",    72'(bus.mem_we_o), 72'(0));
    check_output("rst_addr",  72'(bus.mem_addr_o), 72'(0));
    check_output("rst_wdata", 72'(bus.mem_wdata_o), 72'(0));
    check_output("rst_err",   72'(bus.err_o), 72'(0));
    rst_n = 1'b1;
    wait_clks(4);

    $display("[TB] basic write to IMEM");
    exp_q.push_back(mk(32'h1000_0000, 32'hDEAD_BEEF));
    send_frame(8'h01, 32'h1000_0000);
    send_frame(8'h02, 32'hDEAD_BEEF);
    wait_drain("drain_basic", 100);
    check_output("basic_wcnt", 72'(write_cnt), 72'(1));
    check_output("basic_err",  72'(bus.err_o), 72'(0));

    $display("[TB] stalled write");
    bus.mem_ready_i = 1'b0;
    exp_q.push_back(mk(32'h1000_0000, 32'hCAFE_F00D));
    send_frame(8'h01, 32'h1000_0000);
    send_frame(8'h02, 32'hCAFE_F00D);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      #1;
      check_output("stall_hold", {7'd0, bus.mem_we_o, bus.mem_addr_o, bus.mem_wdata_o},
                   {7'd0, 1'b1, 32'h1000_0000, 32'hCAFE_F00D});
    end
    @(negedge clk);
    bus.mem_ready_i = 1'b1;
    @(negedge clk);
    #1;
    check_output("stall_drop_we", 72'(bus.mem_we_o), 72'(0));
    wait_drain("drain_stall", 10);
    check_output("stall_wcnt", 72'(write_cnt), 72'(2));

    $display("[TB] bad command then SRAM write");
    apply_stimulus(8'h7F);
    wait_clks(4);
    check_output("badcmd_err",  72'(bus.err_o), 72'(1));
    check_output("badcmd_wcnt", 72'(write_cnt), 72'(2));
    exp_q.push_back(mk(32'h2000_0000, 32'h0000_0005));
    send_frame(8'h01, 32'h2000_0000);
    send_frame(8'h02, 32'h0000_0005);
    wait_drain("drain_sram", 100);
    check_output("sram_wcnt",  72'(write_cnt), 72'(3));
    check_output("err_sticky", 72'(bus.err_o), 72'(1));

    $display("[TB] back-to-back data frames");
`ifdef SPI_PROG_ADDR_AUTOINC_EN
    second_addr = 32'h1000_4004;
`else
    second_addr = 32'h1000_4000;
`endif
    send_frame(8'h01, 32'h1000_4000);
    exp_q.push_back(mk(32'h1000_4000, 32'h1122_3344));
    exp_q.push_back(mk(second_addr,   32'h5566_7788));
    send_frame(8'h02, 32'h1122_3344);
    send_frame(8'h02, 32'h5566_7788);
    wait_drain("drain_b2b", 100);
    check_output("b2b_wcnt", 72'(write_cnt), 72'(5));

    $display("[TB] partial byte discarded");
    apply_stimulus(8'h01);
    apply_stimulus(8'h10);
    apply_stimulus(8'hF8, 5);
    apply_stimulus(8'h00);
    apply_stimulus(8'h00);
    apply_stimulus(8'h08);
    exp_q.push_back(mk(32'h1000_0008, 32'h0000_00AA));
    send_frame(8'h02, 32'h0000_00AA);
    wait_drain("drain_partial", 100);
    check_output("partial_wcnt", 72'(write_cnt), 72'(6));

    $display("[TB] MISO echo");
    apply_stimulus(8'hA5);
    apply_stimulus(8'h3C);
    check_output("miso_echo_a5", 72'(miso_cap), 72'(8'hA5));
    apply_stimulus(8'h00);
    check_output("miso_echo_3c", 72'(miso_cap), 72'(8'h3C));

    $display("[TB] reset mid data frame");
    apply_stimulus(8'h02);
    apply_stimulus(8'hDE);
    apply_stimulus(8'hAD);
    rst_n = 1'b0;
    #1;
    check_output("midrst_we",    72'(bus.mem_we_o), 72'(0));
    check_output("midrst_addr",  72'(bus.mem_addr_o), 72'(0));
    check_output("midrst_wdata", 72'(bus.mem_wdata_o), 72'(0));
    check_output("midrst_err",   72'(bus.err_o), 72'(0));
    check_output("midrst_miso",  72'(bus.miso_o), 72'(0));
    wait_clks(3);
    rst_n = 1'b1;
    wait_clks(4);
    exp_q.push_back(mk(32'h0000_0000, 32'h0102_0304));
    send_frame(8'h02, 32'h0102_0304);
    wait_drain("drain_after_rst", 100);
    check_output("after_rst_wcnt", 72'(write_cnt), 72'(7));
    check_output("after_rst_err",  72'(bus.err_o), 72'(0));

    wait_clks(10);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
